// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic [31:0] instructionAddress;
   logic [31:0] instruction;
   logic        ifidValid;
   logic [31:0] ifidPc;
   logic [31:0] ifidPcPlus4;
   logic [31:0] ifidInstr;
   logic        halted;

   modport master (
      input  stall, redirect, redirectTarget, instruction,
      output instructionAddress, ifidValid, ifidPc, ifidPcPlus4, ifidInstr, halted
   );

   modport slave (
      output stall, redirect, redirectTarget, instruction,
      input  instructionAddress, ifidValid, ifidPc, ifidPcPlus4, ifidInstr, halted
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, IF/ID pipeline register, stall and redirect/flush.
// Define HALT_ON_ZERO_EN to stop fetching on an all-zero instruction word.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic            clk,
   input logic            reset,
   fetch_stage_if.master  fetch
);
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
`ifdef HALT_ON_ZERO_EN
   logic        halted_q, halted_d;
`endif

   always_comb begin
      pc_d         = pc_q;
      valid_d      = valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
`ifdef HALT_ON_ZERO_EN
      halted_d     = halted_q;
`endif
      if (fetch.redirect) begin
         pc_d         = {fetch.redirectTarget[31:2], 2'b00};
         valid_d      = 1'b0;
         ifid_instr_d = NOP_INSTR;
`ifdef HALT_ON_ZERO_EN
         halted_d     = 1'b0;
`endif
      end else if (fetch.stall) begin
         // hold everything
`ifdef HALT_ON_ZERO_EN
      end else if (halted_q || fetch.instruction == '0) begin
         valid_d      = 1'b0;
         ifid_instr_d = NOP_INSTR;
         halted_d     = 1'b1;
`endif
      end else begin
         valid_d      = 1'b1;
         ifid_pc_d    = pc_q;
         ifid_pc4_d   = pc_q + 32'd4;
         ifid_instr_d = fetch.instruction;
         pc_d         = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         valid_q      <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= 32'd4;
         ifid_instr_q <= NOP_INSTR;
`ifdef HALT_ON_ZERO_EN
         halted_q     <= 1'b0;
`endif
      end else begin
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
`ifdef HALT_ON_ZERO_EN
         halted_q     <= halted_d;
`endif
      end
   end

   assign fetch.instructionAddress = pc_q;
   assign fetch.ifidValid          = valid_q;
   assign fetch.ifidPc             = ifid_pc_q;
   assign fetch.ifidPcPlus4        = ifid_pc4_q;
   assign fetch.ifidInstr          = ifid_instr_q;
`ifdef HALT_ON_ZERO_EN
   assign fetch.halted             = halted_q;
`else
   assign fetch.halted             = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small combinational instruction-memory image.
module tb_fetch_stage;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fetch (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h00: mem_word = 32'h0640_0093;
         32'h04: mem_word = 32'h0200_0193;
         32'h08: mem_word = 32'h0011_A023;
         32'h0C: mem_word = 32'h0C80_0113;
         32'h10: mem_word = 32'h0010_0093;
         32'h14: mem_word = 32'h0001_8203;
         32'h18: mem_word = 32'h0020_0113;
         32'h1C: mem_word = 32'h00A2_8313;
         32'h20: mem_word = 32'h0000_0000;
         32'h24: mem_word = 32'h0030_0193;
         default: mem_word = 32'h0000_0013;
      endcase
   endfunction

   assign bus.instruction = mem_word(bus.instructionAddress);

   // {valid, pc, pc+4, instr, fetch address, halted}
   function automatic logic [129:0] snap();
      snap = {bus.ifidValid, bus.ifidPc, bus.ifidPcPlus4, bus.ifidInstr,
              bus.instructionAddress, bus.halted};
   endfunction

   function automatic logic [129:0] expect_of(input logic v, input logic [31:0] pc,
                                              input logic [31:0] instr, input logic [31:0] addr,
                                              input logic h);
      expect_of = {v, pc, pc + 32'd4, instr, addr, h};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [129:0] e;
      reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirectTarget = '0;
      step(); step();
      e = expect_of(1'b0, 32'h0, 32'h13, 32'h0, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL reset got %h want %h", snap(), e);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_instr [3];
      logic [129:0] e;
      exp_instr[0] = 32'h0640_0093; exp_instr[1] = 32'h0200_0193; exp_instr[2] = 32'h0011_A023;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         e = expect_of(1'b1, 32'(i * 4), exp_instr[i], 32'(i * 4 + 4), 1'b0);
         n_checks++;
         if (snap() !== e) begin
            n_fail++; $display("FAIL seq[%0d] got %h want %h", i, snap(), e);
         end
      end
   endtask

   task automatic test_stall();
      logic [129:0] e;
      bus.stall = 1'b1;
      e = expect_of(1'b1, 32'h8, 32'h0011_A023, 32'hC, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (snap() !== e) begin
            n_fail++; $display("FAIL stall[%0d] got %h want %h", i, snap(), e);
         end
      end
      bus.stall = 1'b0;
      step();
      e = expect_of(1'b1, 32'hC, 32'h0C80_0113, 32'h10, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL stall_release got %h want %h", snap(), e);
      end
   endtask

   task automatic test_redirect_stall();
      logic [129:0] e;
      bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirectTarget = 32'h0000_0016;
      step();
      e = expect_of(1'b0, 32'hC, 32'h13, 32'h14, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL redir_bubble got %h want %h", snap(), e);
      end
      bus.redirect = 1'b0; bus.stall = 1'b0;
      step();
      e = expect_of(1'b1, 32'h14, 32'h0001_8203, 32'h18, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL redir_target got %h want %h", snap(), e);
      end
      step(); step();
      e = expect_of(1'b1, 32'h1C, 32'h00A2_8313, 32'h20, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL pre_zero got %h want %h", snap(), e);
      end
   endtask

   task automatic test_zero_word();
      logic [129:0] e;
`ifdef HALT_ON_ZERO_EN
      for (int i = 0; i < 2; i++) begin
         step();
         e = expect_of(1'b0, 32'h1C, 32'h13, 32'h20, 1'b1);
         n_checks++;
         if (snap() !== e) begin
            n_fail++; $display("FAIL halt[%0d] got %h want %h", i, snap(), e);
         end
      end
      bus.stall = 1'b1;
      step();
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL halt_stall got %h want %h", snap(), e);
      end
      bus.stall = 1'b0;
      bus.redirect = 1'b1; bus.redirectTarget = 32'h0;
      step();
      e = expect_of(1'b0, 32'h1C, 32'h13, 32'h0, 1'b0);
`else
      step();
      e = expect_of(1'b1, 32'h20, 32'h0, 32'h24, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL zero_pass got %h want %h", snap(), e);
      end
      step();
      e = expect_of(1'b1, 32'h24, 32'h0030_0193, 32'h28, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL after_zero got %h want %h", snap(), e);
      end
      bus.redirect = 1'b1; bus.redirectTarget = 32'h0;
      step();
      e = expect_of(1'b0, 32'h24, 32'h13, 32'h0, 1'b0);
`endif
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL redir_zero got %h want %h", snap(), e);
      end
      bus.redirect = 1'b0;
      step();
      e = expect_of(1'b1, 32'h0, 32'h0640_0093, 32'h4, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL refetch got %h want %h", snap(), e);
      end
   endtask

   task automatic test_mid_reset();
      logic [129:0] e;
      step(); step(); step();
      e = expect_of(1'b1, 32'hC, 32'h0C80_0113, 32'h10, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL pre_reset got %h want %h", snap(), e);
      end
      reset = 1'b1; bus.stall = 1'b1;
      step();
      e = expect_of(1'b0, 32'h0, 32'h13, 32'h0, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL mid_reset got %h want %h", snap(), e);
      end
      reset = 1'b0; bus.stall = 1'b0;
      step();
      e = expect_of(1'b1, 32'h0, 32'h0640_0093, 32'h4, 1'b0);
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL resume got %h want %h", snap(), e);
      end
   endtask

   task automatic test_wrap();
      logic [129:0] e;
      bus.redirect = 1'b1; bus.redirectTarget = 32'hFFFF_FFFF;
      step();
      bus.redirect = 1'b0;
      n_checks++;
      if (bus.instructionAddress !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL wrap_addr got %h want %h", bus.instructionAddress, 32'hFFFF_FFFC);
      end
      step();
      e = {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h13, 32'h0, 1'b0};
      n_checks++;
      if (snap() !== e) begin
         n_fail++; $display("FAIL wrap got %h want %h", snap(), e);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_zero_word();
      test_mid_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
